pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the six-stage pipeline. It merges per-stage stall requests and an exception flush into the stall[5:0] vector consumed by the PC register and all inter-stage latches. It also owns the FSM for multi-cycle EX operations such as divide, holding EX for a programmed cycle count, and keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_stall_controller.sv | 194 +++++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central stall/flush sequencer for the six-stage pipeline. It merges the
// per-stage stall requests and the exception flush into one stall vector.
// The vector is always a contiguous run of ones starting at bit 0. The block
// also runs the multi-cycle EX operation FSM (divide and similar), which holds
// EX for a programmed number of cycles. It also keeps a saturating count of
// cycles in which the PC was stalled.
//
// Ports
//   clock                 rising-edge clock
//   reset                 synchronous, active-high reset; all outputs read 0
//                         while it is high
//   if_stall_request      IF wants to stall (instruction fetch wait)
//   id_stall_request      ID wants to stall (load-use hazard)
//   ex_stall_request      external EX stall request
//   mem_stall_request     MEM wants to stall (data memory wait)
//   ex_multicycle_start   instruction in EX needs a multi-cycle operation
//                         (level, held while the instruction sits in EX)
//   ex_multicycle_cycles  length N of that operation (0 is treated as 1)
//   exception_flush       exception taken, flush the whole pipeline
//   exception_address     handler PC
//   stall[5:0]            [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=WB
//   flush                 flush all latches and redirect the PC
//   flush_address         PC to load while flush is high
//   ex_multicycle_busy    FSM is counting down the operation
//   ex_multicycle_done    operation result is valid in EX this cycle
//   stall_cycle_count     saturating count of cycles with stall[0]=1
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int CYCLE_WIDTH = 6,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   if_stall_request,
  input  logic                   id_stall_request,
  input  logic                   ex_stall_request,
  input  logic                   mem_stall_request,
  input  logic                   ex_multicycle_start,
  input  logic [CYCLE_WIDTH-1:0] ex_multicycle_cycles,
  input  logic                   exception_flush,
  input  logic [31:0]            exception_address,
  output logic [5:0]             stall,
  output logic                   flush,
  output logic [31:0]            flush_address,
  output logic                   ex_multicycle_busy,
  output logic                   ex_multicycle_done,
  output logic [COUNT_WIDTH-1:0] stall_cycle_count
);

  // Stall patterns, one per requesting stage. The lowest stalled stage gets
  // a bubble inserted behind it by the latch where stall[k]=1, stall[k+1]=0.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [CYCLE_WIDTH-1:0] CYCLES_ONE  = CYCLE_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ALL1  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_q;
  logic [CYCLE_WIDTH-1:0] cycles_q;
  logic                   busy_q;
  logic                   done_q;
  logic [COUNT_WIDTH-1:0] stall_count_q;
  logic [COUNT_WIDTH-1:0] stall_count_d;

  logic                   ex_internal_req;
  logic                   ex_any_req;
  logic [CYCLE_WIDTH-1:0] load_cycles;
  logic [5:0]             stall_raw;
  logic                   flush_raw;
  logic [31:0]            flush_address_raw;

  // The FSM itself asks for an EX stall on the start cycle and for every
  // BUSY cycle. In DONE the result is ready, so EX is released even if the
  // start level is still high.
  assign ex_internal_req = ((state_q == IDLE) && ex_multicycle_start) ||
                           (state_q == BUSY);
  assign ex_any_req      = ex_stall_request || ex_internal_req;

  // A zero-length operation still needs one BUSY cycle to produce a result.
  assign load_cycles = (ex_multicycle_cycles == '0) ? CYCLES_ONE
                                                    : ex_multicycle_cycles;

  // Priority merge: a flush overrides everything and releases every latch.
  // Among stall requests, the deepest stage wins because it also freezes all
  // the stages above it.
  always_comb begin
    stall_raw         = STALL_NONE;
    flush_raw         = 1'b0;
    flush_address_raw = 32'h0;
    if (exception_flush) begin
      flush_raw         = 1'b1;
      flush_address_raw = exception_address;
    end else if (mem_stall_request) begin
      stall_raw = STALL_MEM;
    end else if (ex_any_req) begin
      stall_raw = STALL_EX;
    end else if (id_stall_request) begin
      stall_raw = STALL_ID;
    end else if (if_stall_request) begin
      stall_raw = STALL_IF;
    end
  end

  // Multi-cycle EX sequencer. busy/done are registered beside the state, so
  // they change only on clock edges. A flush abandons any operation,
  // including a finished result waiting in DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cycles_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (exception_flush) begin
      state_q  <= IDLE;
      cycles_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ex_multicycle_start) begin
            state_q  <= BUSY;
            cycles_q <= load_cycles;
            busy_q   <= 1'b1;
          end
        end
        BUSY: begin
          cycles_q <= cycles_q - CYCLES_ONE;
          if (cycles_q <= CYCLES_ONE) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          // Stay here until the EX/MEM latch accepts the result. Otherwise
          // the result would be lost and the start level would restart the
          // operation.
          if (!stall_raw[3]) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          cycles_q <= '0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  // Performance counter: one count per PC-stalled cycle. It sticks at
  // all-ones instead of wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_raw[0] && (stall_count_q != COUNT_ALL1)) begin
      stall_count_d = stall_count_q + COUNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  // Every output is forced low while reset is held. This includes the
  // combinational stall vector, which must not freeze the pipeline before
  // the first reset edge.
  assign stall              = reset ? STALL_NONE : stall_raw;
  assign flush              = reset ? 1'b0       : flush_raw;
  assign flush_address      = reset ? 32'h0      : flush_address_raw;
  assign ex_multicycle_busy = reset ? 1'b0       : busy_q;
  assign ex_multicycle_done = reset ? 1'b0       : done_q;
  assign stall_cycle_count  = reset ? '0         : stall_count_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_controller
//
// Drives the stall controller through directed scenarios and a random
// section. It compares every cycle against a behavioural model. The model
// tracks the operation as "BUSY cycles still to run" plus "result waiting".
// It derives the stall vector from the depth of the deepest requesting
// stage. The counter width is reduced so that saturation can be reached.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

  localparam int CW = 6;
  localparam int NW = 10;
  localparam longint COUNT_MAX = (64'd1 << NW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          if_stall_request, id_stall_request;
  logic          ex_stall_request, mem_stall_request;
  logic          ex_multicycle_start;
  logic [CW-1:0] ex_multicycle_cycles;
  logic          exception_flush;
  logic [31:0]   exception_address;
  logic [5:0]    stall;
  logic          flush;
  logic [31:0]   flush_address;
  logic          ex_multicycle_busy, ex_multicycle_done;
  logic [NW-1:0] stall_cycle_count;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int     mBusyLeft;
  bit     mHeld;
  longint mCount;

  // Last sampled DUT values for scenario-level tallies
  logic [5:0] obsStall;
  logic       obsBusy, obsDone;

  always #5 clock = ~clock;

  pipeline_stall_controller #(.CYCLE_WIDTH(CW), .COUNT_WIDTH(NW)) dut (
    .clock               (clock),
    .reset               (reset),
    .if_stall_request    (if_stall_request),
    .id_stall_request    (id_stall_request),
    .ex_stall_request    (ex_stall_request),
    .mem_stall_request   (mem_stall_request),
    .ex_multicycle_start (ex_multicycle_start),
    .ex_multicycle_cycles(ex_multicycle_cycles),
    .exception_flush     (exception_flush),
    .exception_address   (exception_address),
    .stall               (stall),
    .flush               (flush),
    .flush_address       (flush_address),
    .ex_multicycle_busy  (ex_multicycle_busy),
    .ex_multicycle_done  (ex_multicycle_done),
    .stall_cycle_count   (stall_cycle_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit ifr, input bit idr,
                               input bit exr, input bit memr, input bit st,
                               input int n, input bit fl,
                               input logic [31:0] addr);
    reset                = rst;
    if_stall_request     = ifr;
    id_stall_request     = idr;
    ex_stall_request     = exr;
    mem_stall_request    = memr;
    ex_multicycle_start  = st;
    ex_multicycle_cycles = CW'(n);
    exception_flush      = fl;
    exception_address    = addr;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model.
  task automatic cycle();
    bit   internalEx;
    int   depth;
    logic [31:0] expStall, expAddr, expCount;
    bit   expFlush, expBusy, expDone;
    @(negedge clock);
    internalEx = (mBusyLeft > 0) || (!mHeld && ex_multicycle_start);
    if (exception_flush)                     depth = 0;
    else if (mem_stall_request)              depth = 5;
    else if (ex_stall_request || internalEx) depth = 4;
    else if (id_stall_request)               depth = 3;
    else if (if_stall_request)               depth = 2;
    else                                     depth = 0;
    if (reset) begin
      expStall = 0; expFlush = 0; expAddr = 0;
      expBusy = 0; expDone = 0; expCount = 0;
    end else begin
      expStall = (32'd1 << depth) - 1;
      expFlush = exception_flush;
      expAddr  = exception_flush ? exception_address : 32'h0;
      expBusy  = (mBusyLeft > 0);
      expDone  = mHeld;
      expCount = 32'(mCount);
    end
    obsStall = stall;
    obsBusy  = ex_multicycle_busy;
    obsDone  = ex_multicycle_done;
    checkOutput("stall", 32'(stall), expStall);
    checkOutput("flush", 32'(flush), 32'(expFlush));
    checkOutput("flush_address", flush_address, expAddr);
    checkOutput("busy", 32'(ex_multicycle_busy), 32'(expBusy));
    checkOutput("done", 32'(ex_multicycle_done), 32'(expDone));
    checkOutput("stall_cycle_count", 32'(stall_cycle_count), expCount);
    @(posedge clock);
    if (reset) begin
      mBusyLeft = 0; mHeld = 0; mCount = 0;
    end else begin
      if (depth > 0 && mCount < COUNT_MAX) mCount++;
      if (exception_flush) begin
        mBusyLeft = 0; mHeld = 0;
      end else if (mHeld) begin
        if (depth < 4) mHeld = 0;
      end else if (mBusyLeft > 0) begin
        mBusyLeft--;
        if (mBusyLeft == 0) mHeld = 1;
      end else if (ex_multicycle_start) begin
        mBusyLeft = (ex_multicycle_cycles == 0) ? 1 : int'(ex_multicycle_cycles);
      end
    end
    #1;
  endtask

  initial begin
    int nStall, nBusy, nDone;
    bit st;
    int n;
    mBusyLeft = 0; mHeld = 0; mCount = 0;

    // Reset
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    cycle(); cycle();

    // 1: single requests in turn
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 32'h0); cycle();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 32'h0); cycle();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 32'h0); cycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 32'h0); cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0); cycle();

    // 2: id+mem, then flush beats everything
    applyStimulus(0, 0, 1, 0, 1, 0, 0, 0, 32'h0); cycle();
    checkOutput("idmem_stall", 32'(obsStall), 32'h1F);
    applyStimulus(0, 0, 1, 1, 1, 1, 5, 1, 32'hBFC00380); cycle();
    checkOutput("flush_stall", 32'(obsStall), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0); cycle();

    // 3: N=4, start held through DONE
    nStall = 0; nBusy = 0; nDone = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 4, 0, 32'h0); cycle();
      if (obsStall == 6'b001111) nStall++;
      if (obsBusy) nBusy++;
      if (obsDone) nDone++;
    end
    checkOutput("n4_stall_cycles", 32'(nStall), 32'd5);
    checkOutput("n4_busy_cycles", 32'(nBusy), 32'd4);
    checkOutput("n4_done_cycles", 32'(nDone), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0); cycle(); cycle();

    // 4: mem stall holds DONE
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 4, 0, 32'h0); cycle();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 1, 4, 0, 32'h0); cycle();
      checkOutput("done_hold", 32'(obsDone), 32'd1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0); cycle(); cycle();

    // 5: N=0 behaves as 1; flush during long BUSY
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 32'h0); cycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0); cycle();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 32, 0, 32'h0); cycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 32, 1, 32'h80000180); cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0); cycle(); cycle();

    // 6: saturate the counter, then reset mid-BUSY
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 1040; i++) cycle();
    checkOutput("saturated", 32'(stall_cycle_count), 32'(COUNT_MAX));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 20, 0, 32'h0); cycle();
    end
    applyStimulus(1, 0, 0, 0, 0, 1, 20, 0, 32'h0); cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0); cycle(); cycle();

    // Random section
    st = 0; n = 3;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        st = ~st;
        n  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63)
                                          : $urandom_range(0, 6);
      end
      applyStimulus($urandom_range(0, 149) == 0,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 8) == 0,
                    $urandom_range(0, 6) == 0,
                    st, n,
                    $urandom_range(0, 29) == 0,
                    $urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
